// File: rtl/cplx_pkg.sv
// Shared defaults and types for the complex frame accumulator.
package cplx_pkg;

    localparam int unsigned IN_W_DEF    = 32;
    localparam int unsigned GUARD_DEF   = 8;
    localparam int unsigned MAX_LEN_DEF = 256;

    function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned guard);
        return in_w + guard;
    endfunction

    localparam int unsigned ACC_W_DEF = acc_w(IN_W_DEF, GUARD_DEF);

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] re;
        logic signed [ACC_W_DEF-1:0] im;
        logic                        ovf;
    } sat_sum_t;

endpackage

// File: rtl/cplx_sat_add.sv
// Signed saturating adder: clamps to the W-bit two's complement range and flags the clamp.
module cplx_sat_add
    import cplx_pkg::*;
#(
    parameter int unsigned W = ACC_W_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    logic signed [W:0] full;

    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        // The two top bits disagree only when the true sum left the W-bit range.
        ovf  = full[W] ^ full[W-1];
        if (!ovf)
            sum = full[W-1:0];
        else if (full[W])
            sum = {1'b1, {(W-1){1'b0}}};
        else
            sum = {1'b0, {(W-1){1'b1}}};
    end

endmodule

// File: rtl/cplx_acc_frame.sv
// Frame accumulator for complex products: saturating per-component sums,
// one result per frame over valid/ready, with sample count and overflow flag.
module cplx_acc_frame
    import cplx_pkg::*;
#(
    parameter  int unsigned IN_W    = IN_W_DEF,
    parameter  int unsigned GUARD   = GUARD_DEF,
    parameter  int unsigned MAX_LEN = MAX_LEN_DEF,
    localparam int unsigned ACC_W   = acc_w(IN_W, GUARD),
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_re,
    output logic signed [ACC_W-1:0] out_im,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);

    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] ext_re;
    logic signed [ACC_W-1:0] ext_im;
    logic signed [ACC_W-1:0] sum_re;
    logic signed [ACC_W-1:0] sum_im;
    logic                    ovf_re;
    logic                    ovf_im;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    accept;
    logic                    closing;
    logic                    xfer;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign closing  = accept & (in_last | (cnt == CNT_W'(MAX_LEN - 1)));

    assign ext_re = {{GUARD{in_re[IN_W-1]}}, in_re};
    assign ext_im = {{GUARD{in_im[IN_W-1]}}, in_im};

    cplx_sat_add #(.W(ACC_W)) u_add_re (
        .a   (acc_re),
        .b   (ext_re),
        .sum (sum_re),
        .ovf (ovf_re)
    );

    cplx_sat_add #(.W(ACC_W)) u_add_im (
        .a   (acc_im),
        .b   (ext_im),
        .sum (sum_im),
        .ovf (ovf_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re    <= '0;
            acc_im    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            acc_re    <= '0;
            acc_im    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (closing) begin
            // A close overrides any same-cycle transfer: the new result replaces it.
            out_re    <= sum_re;
            out_im    <= sum_im;
            out_cnt   <= cnt + 1'b1;
            out_ovf   <= ovf | ovf_re | ovf_im;
            out_valid <= 1'b1;
            acc_re    <= '0;
            acc_im    <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                acc_re <= sum_re;
                acc_im <= sum_im;
                cnt    <= cnt + 1'b1;
                ovf    <= ovf | ovf_re | ovf_im;
            end
            if (xfer)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cplx_acc_frame.sv
// Bench for cplx_acc_frame: a wide default instance and a narrow one (ACC_W=5, MAX_LEN=4).
module tb_cplx_acc_frame;
    import cplx_pkg::*;

    localparam int A_IN = 32, A_ACC = 40, A_CNT = 9;
    localparam int B_IN = 4,  B_ACC = 5,  B_CNT = 3;

    logic clk, rst_n, clear;

    logic                    a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
    logic signed [A_IN-1:0]  a_in_re, a_in_im;
    logic signed [A_ACC-1:0] a_out_re, a_out_im;
    logic [A_CNT-1:0]        a_out_cnt;

    logic                    b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic signed [B_IN-1:0]  b_in_re, b_in_im;
    logic signed [B_ACC-1:0] b_out_re, b_out_im;
    logic [B_CNT-1:0]        b_out_cnt;

    cplx_acc_frame #(.IN_W(32), .GUARD(8), .MAX_LEN(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_re(a_in_re), .in_im(a_in_im),
        .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_re(a_out_re), .out_im(a_out_im), .out_cnt(a_out_cnt), .out_ovf(a_out_ovf)
    );

    cplx_acc_frame #(.IN_W(4), .GUARD(1), .MAX_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_re(b_in_re), .in_im(b_in_im),
        .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_re(b_out_re), .out_im(b_out_im), .out_cnt(b_out_cnt), .out_ovf(b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        sat_sum_t s;
        int       cnt;
    } exp_t;

    typedef struct {
        bit     sel_b;
        int     re;
        int     im;
        bit     last;
        int     gap;
        bit     has_exp;
        longint ere;
        longint eim;
        int     ecnt;
        bit     eovf;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input longint re, input longint im, input int cnt, input bit ovf);
        exp_t e;
        e.s.re  = re[ACC_W_DEF-1:0];
        e.s.im  = im[ACC_W_DEF-1:0];
        e.s.ovf = ovf;
        e.cnt   = cnt;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_result", 1, 0);
            end else begin
                e = qa.pop_front();
                check("a_out_re",  longint'(a_out_re), longint'($signed(e.s.re)));
                check("a_out_im",  longint'(a_out_im), longint'($signed(e.s.im)));
                check("a_out_cnt", longint'(a_out_cnt), longint'(e.cnt));
                check("a_out_ovf", longint'(a_out_ovf), longint'(e.s.ovf));
            end
        end
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_result", 1, 0);
            end else begin
                e = qb.pop_front();
                check("b_out_re",  longint'(b_out_re), longint'($signed(e.s.re)));
                check("b_out_im",  longint'(b_out_im), longint'($signed(e.s.im)));
                check("b_out_cnt", longint'(b_out_cnt), longint'(e.cnt));
                check("b_out_ovf", longint'(b_out_ovf), longint'(e.s.ovf));
            end
        end
    end

    task automatic idle();
        a_in_valid = 1'b0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0;
    endtask

    // Called just after an active edge; returns just after the edge that accepted the sample.
    task automatic drive(input bit sel, input int re, input int im, input bit last, inout int stalls);
        int n;
        bit rdy;
        n = 0;
        a_in_valid = !sel;
        b_in_valid = sel;
        if (sel) begin
            b_in_re = 4'(re); b_in_im = 4'(im); b_in_last = last;
        end else begin
            a_in_re = re; a_in_im = im; a_in_last = last;
        end
        forever begin
            @(negedge clk);
            rdy = sel ? b_in_ready : a_in_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                check("drive_timeout", longint'(n), 0);
                break;
            end
        end
        stalls += n;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    vec_t vt[$];
    int   stalls;
    logic signed [A_ACC-1:0] snap_re;
    logic [A_CNT-1:0]        snap_cnt;

    initial begin
        // Back-to-back A frames, then narrow-instance saturation and forced closes.
        vt.push_back('{0,  2,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{0,  2,  0, 1, 0, 1,   4,   0, 2, 0});
        vt.push_back('{0,  0,  5, 1, 0, 1,   0,   5, 1, 0});
        vt.push_back('{1,  7,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  7,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  7,  0, 1, 0, 1,  15,   0, 3, 1});
        vt.push_back('{1, -8,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1, -8,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1, -8,  0, 1, 0, 1, -16,   0, 3, 1});
        vt.push_back('{1,  1,  0, 1, 0, 1,   1,   0, 1, 0});
        vt.push_back('{1,  0, -8, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  0, -8, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  0, -1, 1, 0, 1,   0, -16, 3, 1});
        vt.push_back('{1,  7,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  7,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  7,  0, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1, -8,  0, 1, 0, 1,   7,   0, 4, 1});
        vt.push_back('{1,  1,  1, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  1,  1, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  1,  1, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  1,  1, 0, 0, 1,   4,   4, 4, 0});
        vt.push_back('{1,  1,  1, 0, 0, 0,   0,   0, 0, 0});
        vt.push_back('{1,  1,  1, 1, 3, 1,   2,   2, 2, 0});

        rst_n = 1'b0; clear = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        a_in_re = '0; a_in_im = '0; b_in_re = '0; b_in_im = '0;
        idle();
        stalls = 0;

        #1;
        check("rst_out_valid", longint'(a_out_valid), 0);
        check("rst_out_re",    longint'(a_out_re), 0);
        check("rst_out_cnt",   longint'(a_out_cnt), 0);
        check("rst_b_valid",   longint'(b_out_valid), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", longint'(a_in_ready), 1);

        // Basic sum with one-cycle latency after the closing accept.
        drive(0, 1, 2, 0, stalls);
        drive(0, 3, -4, 0, stalls);
        check("lat_before_last", longint'(a_out_valid), 0);
        qa.push_back(mk(-1, 8, 3, 0));
        drive(0, -5, 10, 1, stalls);
        check("lat_after_last", longint'(a_out_valid), 1);
        idle();
        @(posedge clk); #1;
        check("lat_one_cycle", longint'(a_out_valid), 0);

        stalls = 0;
        foreach (vt[i]) begin
            repeat (vt[i].gap) begin
                idle();
                @(posedge clk); #1;
            end
            if (vt[i].has_exp) begin
                if (vt[i].sel_b) qb.push_back(mk(vt[i].ere, vt[i].eim, vt[i].ecnt, vt[i].eovf));
                else             qa.push_back(mk(vt[i].ere, vt[i].eim, vt[i].ecnt, vt[i].eovf));
            end
            drive(vt[i].sel_b, vt[i].re, vt[i].im, vt[i].last, stalls);
        end
        idle();
        check("full_rate_stalls", longint'(stalls), 0);
        repeat (2) @(posedge clk); #1;

        // Backpressure: pending result holds, then is consumed in the same cycle a new frame starts.
        a_out_ready = 1'b0;
        qa.push_back(mk(1, 1, 1, 0));
        drive(0, 1, 1, 1, stalls);
        idle();
        snap_re = a_out_re; snap_cnt = a_out_cnt;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_in_ready",  longint'(a_in_ready), 0);
            check("bp_out_valid", longint'(a_out_valid), 1);
            check("bp_out_re",    longint'(a_out_re), longint'(snap_re));
            check("bp_out_cnt",   longint'(a_out_cnt), longint'(snap_cnt));
        end
        qa.push_back(mk(7, 7, 1, 0));
        a_in_re = 7; a_in_im = 7; a_in_last = 1'b1; a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", longint'(a_in_ready), 1);
        @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk); #1;

        // Clear mid-frame, discarding the sample presented in the clear cycle.
        drive(0, 3, 3, 0, stalls);
        drive(0, 3, 3, 0, stalls);
        clear = 1'b1;
        a_in_re = 9; a_in_im = 9; a_in_last = 1'b1; a_in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        idle();
        qa.push_back(mk(2, 2, 1, 0));
        drive(0, 2, 2, 1, stalls);
        idle();
        repeat (2) @(posedge clk); #1;

        // Clear also drops a pending result.
        a_out_ready = 1'b0;
        drive(0, 1, 1, 1, stalls);
        idle();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_out_valid", longint'(a_out_valid), 0);
        check("clr_out_re",    longint'(a_out_re), 0);
        check("clr_out_cnt",   longint'(a_out_cnt), 0);

        // Asynchronous reset with a pending result.
        drive(0, 6, 6, 1, stalls);
        idle();
        check("pre_rst_valid", longint'(a_out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", longint'(a_out_valid), 0);
        check("arst_out_re",    longint'(a_out_re), 0);
        check("arst_out_im",    longint'(a_out_im), 0);
        check("arst_out_cnt",   longint'(a_out_cnt), 0);
        check("arst_out_ovf",   longint'(a_out_ovf), 0);
        check("arst_in_ready",  longint'(a_in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-frame must discard the partial sum.
        drive(0, 4, 4, 0, stalls);
        idle();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        qa.push_back(mk(5, 6, 1, 0));
        drive(0, 5, 6, 1, stalls);
        idle();

        repeat (5) @(posedge clk); #1;
        check("a_queue_drained", longint'(qa.size()), 0);
        check("b_queue_drained", longint'(qb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
